// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control unit: Moore sequencing FSM with an ALU decoder and a
// memory-ready handshake that lets FETCH, MEMRD and MEMWR stall.
module mips_multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_en,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic       w_ready;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;

  assign w_ready = USE_MEM_READY ? mem_ready : 1'b1;
  assign state   = r_state;

  // R-type function decode; unknown codes fall back to add but are flagged
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = ALU_ADD;
    case (funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = w_funct_ok ? S_ALUWB : S_FETCH;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore outputs, except the FETCH handshake strobes and the branch PC load
  always_comb begin
    mem_req    = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = w_ready;
        pc_en   = w_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = w_funct_alu;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pc_en      = zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pc_en = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      mem_req    = 1'b0;
      pc_en      = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a per-instruction trace model predicts state and
// outputs cycle by cycle from the instruction class, stall lengths and zero flag.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_en(pc_en), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8,
    ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;

  typedef struct {
    logic       mr;
    logic       zr;
    logic [5:0] opv;
    logic [5:0] fv;
    logic [3:0] st;
    logic [15:0] o;
  } step_t;

  step_t exp_q[$];

  // Output vector: mem_req,pc_en,iord,irwrite,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol
  function automatic logic [15:0] mk(input logic mreq, pce, iordv, irw, mw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu);
    return {mreq, pce, iordv, irw, mw, rw, rd, m2r, asa, asb, pcs, alu};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic mr, zr, input logic [5:0] opv, fv,
                               input logic [3:0] st, input logic [15:0] o);
    exp_q.push_back('{mr, zr, opv, fv, st, o});
  endfunction

  // Returns {recognised, alu code} for an R-type function field
  function automatic logic [3:0] funct_alu(input logic [5:0] fv);
    case (fv)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  function automatic void model_idle();
    push(1'b0, rbit(), 6'd0, 6'd0, FETCH, mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010));
  endfunction

  function automatic void model_instr(input logic [5:0] opv, fv, input int fst, mst,
                                      input logic zv);
    logic [3:0] fa;
    for (int i = 0; i < fst; i++)
      push(1'b0, rbit(), opv, fv, FETCH, mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010));
    push(1'b1, rbit(), opv, fv, FETCH, mk(1,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010));
    push(rbit(), rbit(), opv, fv, DECODE, mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010));
    case (opv)
      6'b000000: begin
        fa = funct_alu(fv);
        push(rbit(), rbit(), opv, fv, EXECUTE, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, fa[2:0]));
        if (fa[3])
          push(rbit(), rbit(), opv, fv, ALUWB, mk(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b010));
      end
      6'b100011: begin
        push(rbit(), rbit(), opv, fv, MEMADR, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010));
        for (int i = 0; i <= mst; i++)
          push(i == mst, rbit(), opv, fv, MEMRD, mk(1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010));
        push(rbit(), rbit(), opv, fv, MEMWB, mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010));
      end
      6'b101011: begin
        push(rbit(), rbit(), opv, fv, MEMADR, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010));
        for (int i = 0; i <= mst; i++)
          push(i == mst, rbit(), opv, fv, MEMWR, mk(1,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010));
      end
      6'b000100:
        push(rbit(), zv, opv, fv, BRANCH, mk(0,zv,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110));
      6'b001000: begin
        push(rbit(), rbit(), opv, fv, ADDIEX, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010));
        push(rbit(), rbit(), opv, fv, ADDIWB, mk(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010));
      end
      6'b000010:
        push(rbit(), rbit(), opv, fv, JUMP, mk(0,1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010));
      default: ;
    endcase
  endfunction

  task automatic drive_step(input logic rs, mr, zr, input logic [5:0] opv, fv,
                            output logic [3:0] st, output logic [15:0] o);
    @(negedge clk);
    rst = rs; mem_ready = mr; zero = zr; op = opv; funct = fv;
    #1;
    st = state;
    o  = {mem_req, pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
          alusrcb, pcsrc, alucontrol};
  endtask

  task automatic test_reset();
    logic [3:0] st; logic [15:0] o;
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0, rbit(), rbit(), 6'($urandom), 6'($urandom), st, o);
      n_tests++;
      if (st !== FETCH || o !== 16'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: state=%0d outs=%h, expected state=0 outs=0000", i, st, o);
      end
    end
  endtask

  task automatic test_r_type();
    logic [3:0] st; logic [15:0] o; step_t s;
    model_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
    model_instr(6'b000000, 6'b100010, 1, 0, 1'b0);
    model_instr(6'b000000, 6'b101010, 0, 0, 1'b0);
    model_instr(6'b000000, 6'b000000, 0, 0, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL r_type: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] st; logic [15:0] o; step_t s; int rd_cycles = 0;
    model_instr(6'b100011, 6'($urandom), 0, 3, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      if (st == MEMRD) rd_cycles++;
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL lw_stall: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
    n_tests++;
    if (rd_cycles !== 4) begin
      n_fail++;
      $display("FAIL lw_memrd_len: got %0d cycles, expected 4", rd_cycles);
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0] st; logic [15:0] o; step_t s; int wr_cycles = 0;
    model_instr(6'b101011, 6'($urandom), 0, 2, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      if (o[11]) wr_cycles++;
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL sw_stall: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
    n_tests++;
    if (wr_cycles !== 3) begin
      n_fail++;
      $display("FAIL sw_memwrite_len: got %0d cycles, expected 3", wr_cycles);
    end
  endtask

  task automatic test_beq();
    logic [3:0] st; logic [15:0] o; step_t s;
    model_instr(6'b000100, 6'($urandom), 0, 0, 1'b1);
    model_instr(6'b000100, 6'($urandom), 2, 0, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL beq: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] st; logic [15:0] o; step_t s;
    model_instr(6'b111111, 6'($urandom), 0, 0, 1'b0);
    model_instr(6'b000000, 6'b000000, 0, 0, 1'b0);
    model_instr(6'b001001, 6'($urandom), 1, 0, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL illegal: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [3:0] st; logic [15:0] o; step_t s;
    model_instr(6'b101011, 6'd0, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL abort_pre: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
    exp_q.delete();
    drive_step(1'b0, 1'b0, 1'b0, 6'b101011, 6'd0, st, o);
    n_tests++;
    if (st !== MEMWR || o !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_in_reset: state=%0d outs=%h, expected state=5 outs=0000", st, o);
    end
    model_idle();
    model_instr(6'b000010, 6'($urandom), 0, 0, 1'b0);
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL abort_then_j: state=%0d outs=%h, expected state=%0d outs=%h", st, o, s.st, s.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st; logic [15:0] o; step_t s;
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] opv, fv;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int n = 0; n < 200; n++) begin
      opv = ops[$urandom_range(0, 6)];
      if (n % 17 == 16) opv = 6'($urandom);
      fv = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      model_instr(opv, fv, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end
    model_idle();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      drive_step(1'b1, s.mr, s.zr, s.opv, s.fv, st, o);
      n_tests++;
      if (st !== s.st || o !== s.o) begin
        n_fail++;
        $display("FAIL back_to_back op=%b funct=%b: state=%0d outs=%h, expected state=%0d outs=%h",
                 s.opv, s.fv, st, o, s.st, s.o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_illegal();
    test_reset_mid_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
